// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: PC sequencer with jump/branch redirect, stall hold, range fault and run/step/halt FSM
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ADDR_W    = 5,
  parameter int          ROM_DEPTH = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_en_i,
  input  logic              step_req_i,
  input  logic              halt_req_i,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [31:0]       br_target_i,
  input  logic              jmp_taken_i,
  input  logic [31:0]       jmp_target_i,
  output logic [31:0]       pc_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              inst_valid_o,
  output logic [1:0]        state_o,
  output logic              fault_o,
  output logic [31:0]       retired_cnt_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, FAULT = 2'b11} state_e;
  localparam logic [31:0] ROM_LIMIT = 32'(ROM_DEPTH * 4);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, cnt_q, cnt_d, npc;
  logic        fault_q, fault_d, commit, npc_bad;
  always_comb begin
    commit  = ((state_q == RUN && run_en_i && !halt_req_i) || state_q == STEP) && !stall_i;
    npc     = jmp_taken_i ? jmp_target_i : br_taken_i ? br_target_i : pc_q + 32'd4;
    npc_bad = (npc[1:0] != 2'b00) || (npc >= ROM_LIMIT);
    pc_d    = (commit && !npc_bad) ? npc : pc_q;
    cnt_d   = commit ? cnt_q + 32'd1 : cnt_q;
    fault_d = fault_q || (commit && npc_bad);
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = run_en_i ? RUN : step_req_i ? STEP : IDLE;
      RUN:     state_d = (halt_req_i || !run_en_i) ? IDLE : (commit && npc_bad) ? FAULT : RUN;
      STEP:    state_d = commit ? (npc_bad ? FAULT : IDLE) : STEP;
      default: state_d = FAULT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
  assign pc_o          = pc_q;
  assign rom_addr_o    = pc_q[ADDR_W+1:2];
  assign inst_valid_o  = commit && !rst;
  assign state_o       = state_q;
  assign fault_o       = fault_q;
  assign retired_cnt_o = cnt_q;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed stimulus with a commit scoreboard checked by a negedge monitor
module tb_inst_fetch_ctrl;
  logic        clk = 0, rst = 1, run_en = 0, step_req = 0, halt_req = 0, stall = 0;
  logic        br_taken = 0, jmp_taken = 0;
  logic [31:0] br_target = 0, jmp_target = 0;
  logic [31:0] pc, retired_cnt;
  logic [4:0]  rom_addr;
  logic        inst_valid, fault;
  logic [1:0]  state;
  typedef struct {logic [31:0] pc; logic [31:0] cnt;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  inst_fetch_ctrl dut (
    .clk(clk), .rst(rst), .run_en_i(run_en), .step_req_i(step_req), .halt_req_i(halt_req),
    .stall_i(stall), .br_taken_i(br_taken), .br_target_i(br_target), .jmp_taken_i(jmp_taken),
    .jmp_target_i(jmp_target), .pc_o(pc), .rom_addr_o(rom_addr), .inst_valid_o(inst_valid),
    .state_o(state), .fault_o(fault), .retired_cnt_o(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] c);
    exp_t e;
    e.pc  = p;
    e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic st(input string nm, input logic [31:0] p, input logic [31:0] c,
                    input logic [1:0] s, input logic f);
    chk({nm, "_pc"}, pc, p);
    chk({nm, "_cnt"}, retired_cnt, c);
    chk({nm, "_state"}, 32'(state), 32'(s));
    chk({nm, "_fault"}, 32'(fault), 32'(f));
    chk({nm, "_rom_addr"}, 32'(rom_addr), 32'(p[6:2]));
  endtask

  always @(negedge clk) begin
    if (inst_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_commit: got commit at pc %h expected none", pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("commit_pc", pc, e.pc);
        chk("commit_cnt", retired_cnt, e.cnt);
      end
    end
  end

  initial begin
    tick;
    tick;
    rst = 0;
    st("reset", 32'h0, 0, 2'b00, 0);
    chk("reset_valid", 32'(inst_valid), 0);
    run_en = 1;
    tick;
    st("run_enter", 32'h0, 0, 2'b01, 0);
    for (int i = 0; i < 8; i++) begin
      push(32'(4 * i), 32'(i));
      tick;
      if (i == 4) st("run5", 32'h14, 5, 2'b01, 0);
    end
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("stall_valid", 32'(inst_valid), 0);
      tick;
      st("stall", 32'h20, 8, 2'b01, 0);
    end
    stall = 0;
    push(32'h20, 8);
    tick;
    st("unstall", 32'h24, 9, 2'b01, 0);
    jmp_taken = 1; jmp_target = 32'h18;
    push(32'h24, 9);
    tick;
    jmp_taken = 0;
    br_taken = 1; br_target = 32'h30;
    push(32'h18, 10);
    tick;
    br_taken = 0;
    st("branch", 32'h30, 11, 2'b01, 0);
    for (int i = 0; i < 7; i++) begin
      push(32'(32'h30 + 4 * i), 32'(11 + i));
      tick;
    end
    st("at_4c", 32'h4C, 18, 2'b01, 0);
    jmp_taken = 1; jmp_target = 32'h0C; br_taken = 1; br_target = 32'h30;
    push(32'h4C, 18);
    tick;
    jmp_taken = 0; br_taken = 0;
    st("jmp_prio", 32'h0C, 19, 2'b01, 0);
    halt_req = 1;
    #1 chk("halt_valid", 32'(inst_valid), 0);
    tick;
    halt_req = 0; run_en = 0;
    st("halt", 32'h0C, 19, 2'b00, 0);
    rst = 1;
    tick;
    rst = 0;
    st("reset2", 32'h0, 0, 2'b00, 0);
    for (int k = 0; k < 3; k++) begin
      step_req = 1;
      tick;
      step_req = 0;
      chk("step_state", 32'(state), 32'd2);
      push(32'(4 * k), 32'(k));
      tick;
      chk("step_idle", 32'(state), 32'd0);
      tick;
    end
    st("steps3", 32'h0C, 3, 2'b00, 0);
    step_req = 1;
    tick;
    step_req = 0; stall = 1;
    tick;
    st("step_stall", 32'h0C, 3, 2'b10, 0);
    stall = 0;
    push(32'h0C, 3);
    tick;
    st("step_done", 32'h10, 4, 2'b00, 0);
    run_en = 1;
    tick;
    jmp_taken = 1; jmp_target = 32'h50;
    push(32'h10, 4);
    tick;
    st("fault_range", 32'h10, 5, 2'b11, 1);
    jmp_target = 32'h20; step_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("fault_valid", 32'(inst_valid), 0);
      tick;
      st("fault_frozen", 32'h10, 5, 2'b11, 1);
    end
    jmp_taken = 0; step_req = 0;
    rst = 1;
    tick;
    rst = 0;
    st("reset_fault", 32'h0, 0, 2'b00, 0);
    tick;
    jmp_taken = 1; jmp_target = 32'h06;
    push(32'h0, 0);
    tick;
    jmp_taken = 0;
    st("fault_align", 32'h0, 1, 2'b11, 1);
    rst = 1;
    tick;
    rst = 0;
    tick;
    jmp_taken = 1; jmp_target = 32'h30;
    push(32'h0, 0);
    tick;
    jmp_taken = 0;
    st("at_30", 32'h30, 1, 2'b01, 0);
    rst = 1;
    #1 chk("rst_valid", 32'(inst_valid), 0);
    tick;
    rst = 0; run_en = 0;
    st("rst_run", 32'h0, 0, 2'b00, 0);
    tick;
    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
